// File: rtl/parity_frame_rx.sv
// ---------------------------------------------------------------------------
// parity_frame_rx
//
// Receive side of the even-parity serial link. The transmitter sends
// a start bit (0), DATA_W data bits LSB first, one parity bit, and a stop
// bit (1). This block reassembles the word, checks the parity and the stop
// bit, and pulses valid for one clock when a frame is complete.
//
// Ports:
//   clk        rising-edge clock, the only clock
//   reset      synchronous active-high reset
//   bit_en     bit strobe; sin is only looked at on edges where bit_en=1
//   sin        serial line, idles high
//   data       last received word, data[0] = first data bit on the line
//   valid      one-cycle pulse when data/perr/ferr have just been updated
//   perr       parity mismatch on the last frame
//   ferr       framing error (stop bit was 0) on the last frame
//   busy       high while a frame is in progress (FSM not idle)
//   err_count  saturating count of frames with perr or ferr since reset
//
// Parameters:
//   DATA_W  data bits per frame (>= 1)
//   ODD     0 = even parity, 1 = odd parity
//   CNT_W   width of the error counter
// ---------------------------------------------------------------------------
module parity_frame_rx #(
   parameter int DATA_W = 3,
   parameter int ODD    = 0,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bit_en,
   input  logic              sin,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   output logic              perr,
   output logic              ferr,
   output logic              busy,
   output logic [CNT_W-1:0]  err_count
);

   localparam int             IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
   localparam logic           ODD_BIT  = (ODD != 0);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PAR,
      STOP
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    bitIdx_q, bitIdx_d;
   logic                parity_q, parity_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic                perrPend_q, perrPend_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                valid_q, valid_d;
   logic                perr_q, perr_d;
   logic                ferr_q, ferr_d;
   logic                busy_q, busy_d;
   logic [CNT_W-1:0]    errCnt_q, errCnt_d;

   // Next-state logic. Every register holds by default; the FSM only moves
   // on bit strobes. valid defaults low so it is a single-cycle pulse even
   // when no strobe arrives in the cycle after the stop bit.
   always_comb begin
      state_d    = state_q;
      bitIdx_d   = bitIdx_q;
      parity_d   = parity_q;
      shift_d    = shift_q;
      perrPend_d = perrPend_q;
      data_d     = data_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      errCnt_d   = errCnt_q;
      valid_d    = 1'b0;

      if (bit_en) begin
         case (state_q)
            IDLE: begin
               if (!sin) begin
                  state_d  = DATA;
                  bitIdx_d = '0;
                  parity_d = 1'b0;
               end
            end

            DATA: begin
               // Compare against each position instead of indexing directly
               // so a non-power-of-two DATA_W never writes past the word.
               for (int i = 0; i < DATA_W; i++) begin
                  if (bitIdx_q == IDX_W'(i)) begin
                     shift_d[i] = sin;
                  end
               end
               parity_d = parity_q ^ sin;
               if (bitIdx_q == LAST_IDX) begin
                  state_d = PAR;
               end else begin
                  bitIdx_d = bitIdx_q + IDX_W'(1);
               end
            end

            PAR: begin
               // The parity verdict is held until the stop bit so the
               // visible flags only ever change together with data.
               perrPend_d = (sin != (parity_q ^ ODD_BIT));
               state_d    = STOP;
            end

            STOP: begin
               // A low stop bit is flagged but not taken as the next start
               // bit; the next frame must begin from IDLE on a later strobe.
               data_d  = shift_q;
               perr_d  = perrPend_q;
               ferr_d  = ~sin;
               valid_d = 1'b1;
               if ((perrPend_q || !sin) && (errCnt_q != '1)) begin
                  errCnt_d = errCnt_q + CNT_W'(1);
               end
               state_d = IDLE;
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   // State register. Reset wins over a simultaneous strobe and throws away
   // any partially received frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         bitIdx_q   <= '0;
         parity_q   <= 1'b0;
         shift_q    <= '0;
         perrPend_q <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         busy_q     <= 1'b0;
         errCnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         bitIdx_q   <= bitIdx_d;
         parity_q   <= parity_d;
         shift_q    <= shift_d;
         perrPend_q <= perrPend_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         busy_q     <= busy_d;
         errCnt_q   <= errCnt_d;
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign perr      = perr_q;
   assign ferr      = ferr_q;
   assign busy      = busy_q;
   assign err_count = errCnt_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_parity_frame_rx
//
// Scoreboard bench for parity_frame_rx. Three instances share the same
// serial stimulus: the default even-parity build, an odd-parity build, and
// a build with a 2-bit error counter. The stimulus pushes each frame's
// expected result into a queue just before its stop bit; a monitor pops
// and compares whenever the DUT raises valid.
// ---------------------------------------------------------------------------
module tb_parity_frame_rx;

   localparam int DW = 3;

   typedef struct {
      logic [DW-1:0] data;
      logic          perrEven;
      logic          perrOdd;
      logic          ferr;
      int            cnt0;
      int            cntOdd;
      int            cntSat;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          bitEn = 1'b0;
   logic          sin = 1'b1;

   logic [DW-1:0] data0, dataOdd, dataSat;
   logic          valid0, validOdd, validSat;
   logic          perr0, perrOdd, perrSat;
   logic          ferr0, ferrOdd, ferrSat;
   logic          busy0, busyOdd, busySat;
   logic [7:0]    errCnt0, errCntOdd;
   logic [1:0]    errCntSat;

   exp_t expQ[$];
   int   numCompared = 0;
   int   numMismatched = 0;
   int   modelCnt0 = 0;
   int   modelCntOdd = 0;
   int   modelCntSat = 0;

   always #5 clk = ~clk;

   parity_frame_rx #(.DATA_W(DW), .ODD(0), .CNT_W(8)) dut0 (
      .clk(clk), .reset(reset), .bit_en(bitEn), .sin(sin),
      .data(data0), .valid(valid0), .perr(perr0), .ferr(ferr0),
      .busy(busy0), .err_count(errCnt0)
   );

   parity_frame_rx #(.DATA_W(DW), .ODD(1), .CNT_W(8)) dutOdd (
      .clk(clk), .reset(reset), .bit_en(bitEn), .sin(sin),
      .data(dataOdd), .valid(validOdd), .perr(perrOdd), .ferr(ferrOdd),
      .busy(busyOdd), .err_count(errCntOdd)
   );

   parity_frame_rx #(.DATA_W(DW), .ODD(0), .CNT_W(2)) dutSat (
      .clk(clk), .reset(reset), .bit_en(bitEn), .sin(sin),
      .data(dataSat), .valid(validSat), .perr(perrSat), .ferr(ferrSat),
      .busy(busySat), .err_count(errCntSat)
   );

   // One comparison: counts it and reports a FAIL line on mismatch.
   task automatic checkOutput(input string name, input int actual, input int expected);
      numCompared++;
      if (actual !== expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // One bit strobe carrying bitVal, followed by gap idle cycles.
   task automatic applyStimulus(input logic bitVal, input int gap);
      sin   = bitVal;
      bitEn = 1'b1;
      @(posedge clk);
      #1;
      bitEn = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Records the expected outcome of a frame, keeping the bench's own
   // running error counts (saturating at 255 and 3).
   task automatic pushExpected(input logic [DW-1:0] word, input logic perrEven, input logic ferr);
      exp_t e;
      if (perrEven || ferr) modelCnt0 = (modelCnt0 < 255) ? modelCnt0 + 1 : 255;
      if (!perrEven || ferr) modelCntOdd = (modelCntOdd < 255) ? modelCntOdd + 1 : 255;
      if (perrEven || ferr) modelCntSat = (modelCntSat < 3) ? modelCntSat + 1 : 3;
      e.data     = word;
      e.perrEven = perrEven;
      e.perrOdd  = ~perrEven;
      e.ferr     = ferr;
      e.cnt0     = modelCnt0;
      e.cntOdd   = modelCntOdd;
      e.cntSat   = modelCntSat;
      expQ.push_back(e);
   endtask

   // Full frame. perrEven is the hand-derived even-parity verdict.
   task automatic sendFrame(input logic [DW-1:0] word, input logic parBit, input logic stopBit,
                            input logic perrEven, input int gap);
      applyStimulus(1'b0, gap);
      checkOutput("busy_after_start", int'(busy0), 1);
      for (int i = 0; i < DW; i++) applyStimulus(word[i], gap);
      applyStimulus(parBit, gap);
      pushExpected(word, perrEven, ~stopBit);
      applyStimulus(stopBit, gap);
   endtask

   // Monitor: on any valid, pop one expectation and check all three DUTs.
   // A valid with nothing queued (spurious frame or a stretched pulse)
   // counts as a failure.
   always @(negedge clk) begin
      if (!reset && (valid0 || validOdd || validSat)) begin
         if (expQ.size() == 0) begin
            checkOutput("spurious_valid", 1, 0);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("valid_odd", int'(validOdd), 1);
            checkOutput("valid_sat", int'(validSat), 1);
            checkOutput("data", int'(data0), int'(e.data));
            checkOutput("perr", int'(perr0), int'(e.perrEven));
            checkOutput("ferr", int'(ferr0), int'(e.ferr));
            checkOutput("err_count", int'(errCnt0), e.cnt0);
            checkOutput("data_odd", int'(dataOdd), int'(e.data));
            checkOutput("perr_odd", int'(perrOdd), int'(e.perrOdd));
            checkOutput("err_count_odd", int'(errCntOdd), e.cntOdd);
            checkOutput("err_count_sat", int'(errCntSat), e.cntSat);
         end
      end
   end

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_data"}, int'(data0), 0);
      checkOutput({tag, "_valid"}, int'(valid0), 0);
      checkOutput({tag, "_perr"}, int'(perr0), 0);
      checkOutput({tag, "_ferr"}, int'(ferr0), 0);
      checkOutput({tag, "_busy"}, int'(busy0), 0);
      checkOutput({tag, "_err_count"}, int'(errCnt0), 0);
      checkOutput({tag, "_err_count_odd"}, int'(errCntOdd), 0);
   endtask

   initial begin
      logic [DW-1:0] w;

      // Power-on reset.
      repeat (3) @(posedge clk);
      #1;
      checkResetValues("reset");
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Word 101, correct parity 0, good stop.
      sendFrame(3'b101, 1'b0, 1'b1, 1'b0, 0);

      // All eight words back-to-back with generator parity.
      for (int k = 0; k < 8; k++) begin
         w = 3'(k);
         sendFrame(w, ^w, 1'b1, 1'b0, 0);
      end

      // Word 011 with wrong parity bit 1.
      sendFrame(3'b011, 1'b1, 1'b1, 1'b1, 0);

      // Framing error: word 010, good parity 1, stop 0, then line high.
      sendFrame(3'b010, 1'b1, 1'b0, 1'b0, 0);
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, 0);
      checkOutput("busy_after_ferr", int'(busy0), 0);

      // Slow strobe: bit_en every 4th cycle, word 110, parity 0.
      sendFrame(3'b110, 1'b0, 1'b1, 1'b0, 3);
      repeat (4) @(posedge clk);
      #1;

      // Reset after two data bits, with a strobe on the reset edge.
      applyStimulus(1'b0, 0);
      applyStimulus(1'b1, 0);
      applyStimulus(1'b1, 0);
      checkOutput("busy_mid_frame", int'(busy0), 1);
      reset = 1'b1;
      sin   = 1'b0;
      bitEn = 1'b1;
      @(posedge clk);
      #1;
      bitEn = 1'b0;
      reset = 1'b0;
      sin   = 1'b1;
      modelCnt0   = 0;
      modelCntOdd = 0;
      modelCntSat = 0;
      checkResetValues("mid_reset");
      repeat (3) @(posedge clk);
      #1;
      checkOutput("no_valid_after_reset", int'(valid0), 0);

      // Clean frame after the reset: word 100, parity 1.
      sendFrame(3'b100, 1'b1, 1'b1, 1'b0, 0);

      // Five bad-parity frames: word 001 sent with parity 0.
      for (int k = 0; k < 5; k++) sendFrame(3'b001, 1'b0, 1'b1, 1'b1, 1);

      repeat (6) @(posedge clk);
      #1;
      checkOutput("sat_final", int'(errCntSat), 3);
      checkOutput("err_count_final", int'(errCnt0), 5);
      checkOutput("queue_drained", expQ.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
